// File: rtl/inert_intf.sv
// Inertial-sensor front end: configures the IMU over SPI after reset, then
// reads pitch rate and Z acceleration on every data-ready interrupt and
// presents them with a one-clk vld strobe.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   INT      in   IMU data-ready level (asynchronous)
//   MISO     in   SPI data from IMU
//   SS_n     out  SPI slave select, active-low
//   SCLK     out  SPI clock (clk/16), idles high
//   MOSI     out  SPI data to IMU
//   vld      out  one-clk strobe: new ptch_rt/AZ pair valid
//   ptch_rt  out  raw signed pitch rate {high, low}
//   AZ       out  raw Z acceleration {high, low}
module inert_intf #(
    parameter int unsigned INIT_WAIT_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DIV_W  = 4;
    localparam int unsigned RISE_W = 5;

    // Divider phase at SS_n fall: SCLK high for 4 clk, then falls on wrap.
    localparam logic [DIV_W-1:0]  DIV_START = 4'hC;
    localparam logic [DIV_W-1:0]  DIV_RISE  = 4'h7;
    localparam logic [DIV_W-1:0]  DIV_FALL  = 4'hF;
    localparam logic [RISE_W-1:0] LAST_RISE = 5'd16;

    localparam logic [WORD_W-1:0] CMD_WR0  = 16'h0D02;
    localparam logic [WORD_W-1:0] CMD_WR1  = 16'h1053;
    localparam logic [WORD_W-1:0] CMD_WR2  = 16'h1150;
    localparam logic [WORD_W-1:0] CMD_WR3  = 16'h1460;
    localparam logic [WORD_W-1:0] CMD_RDPL = 16'hA200;
    localparam logic [WORD_W-1:0] CMD_RDPH = 16'hA300;
    localparam logic [WORD_W-1:0] CMD_RDAL = 16'hAC00;
    localparam logic [WORD_W-1:0] CMD_RDAH = 16'hAD00;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_WR0,
        ST_WR1,
        ST_WR2,
        ST_WR3,
        ST_WAIT_INT,
        ST_RD_PL,
        ST_RD_PH,
        ST_RD_AL,
        ST_RD_AH,
        ST_VALID
    } state_e;

    state_e state_q, state_d;

    logic [INIT_WAIT_BITS-1:0] wait_cnt_q;
    logic                      int_meta_q;
    logic                      int_sync_q;
    logic                      issued_q;

    logic                      start_c;
    logic [WORD_W-1:0]         cmd_c;

    logic                      ss_n_q;
    logic [DIV_W-1:0]          div_q;
    logic [WORD_W-1:0]         tx_q;
    logic [BYTE_W-1:0]         rx_q;
    logic [RISE_W-1:0]         rise_cnt_q;
    logic                      done_q;

    logic [BYTE_W-1:0]         pl_q, ph_q, al_q;
    logic [WORD_W-1:0]         ptch_q, az_q;
    logic                      vld_q;

    assign SS_n    = ss_n_q;
    assign SCLK    = div_q[DIV_W-1];
    assign MOSI    = tx_q[WORD_W-1];
    assign vld     = vld_q;
    assign ptch_rt = ptch_q;
    assign AZ      = az_q;

    // Two-flop synchronizer for the asynchronous data-ready level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
        end else begin
            int_meta_q <= INT;
            int_sync_q <= int_meta_q;
        end
    end

    // Post-reset settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_INIT_WAIT) begin
            wait_cnt_q <= wait_cnt_q + INIT_WAIT_BITS'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; each transfer state fires start once, then waits for done.
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        cmd_c   = '0;
        unique case (state_q)
            ST_INIT_WAIT: if (&wait_cnt_q) state_d = ST_WR0;
            ST_WR0: begin
                cmd_c   = CMD_WR0;
                start_c = !issued_q;
                if (done_q) state_d = ST_WR1;
            end
            ST_WR1: begin
                cmd_c   = CMD_WR1;
                start_c = !issued_q;
                if (done_q) state_d = ST_WR2;
            end
            ST_WR2: begin
                cmd_c   = CMD_WR2;
                start_c = !issued_q;
                if (done_q) state_d = ST_WR3;
            end
            ST_WR3: begin
                cmd_c   = CMD_WR3;
                start_c = !issued_q;
                if (done_q) state_d = ST_WAIT_INT;
            end
            ST_WAIT_INT: if (int_sync_q) state_d = ST_RD_PL;
            ST_RD_PL: begin
                cmd_c   = CMD_RDPL;
                start_c = !issued_q;
                if (done_q) state_d = ST_RD_PH;
            end
            ST_RD_PH: begin
                cmd_c   = CMD_RDPH;
                start_c = !issued_q;
                if (done_q) state_d = ST_RD_AL;
            end
            ST_RD_AL: begin
                cmd_c   = CMD_RDAL;
                start_c = !issued_q;
                if (done_q) state_d = ST_RD_AH;
            end
            ST_RD_AH: begin
                cmd_c   = CMD_RDAH;
                start_c = !issued_q;
                if (done_q) state_d = ST_VALID;
            end
            ST_VALID: state_d = ST_WAIT_INT;
            default:  state_d = ST_INIT_WAIT;
        endcase
    end

    // Remembers that the current state's transaction has been launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= 1'b0;
        end else if (start_c) begin
            issued_q <= 1'b1;
        end else if (done_q) begin
            issued_q <= 1'b0;
        end
    end

    // SPI master, mode 3. Only the low byte of each response is consumed, so
    // the receive register keeps the last 8 bits shifted in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_q     <= 1'b1;
            div_q      <= DIV_START;
            tx_q       <= '0;
            rx_q       <= '0;
            rise_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ss_n_q) begin
                if (start_c) begin
                    ss_n_q     <= 1'b0;
                    div_q      <= DIV_START;
                    tx_q       <= cmd_c;
                    rise_cnt_q <= '0;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
                if (div_q == DIV_RISE) begin
                    rx_q       <= {rx_q[BYTE_W-2:0], MISO};
                    rise_cnt_q <= rise_cnt_q + RISE_W'(1);
                end
                if (div_q == DIV_FALL) begin
                    // After the 16th rise the would-be fall ends the frame instead.
                    if (rise_cnt_q == LAST_RISE) begin
                        ss_n_q <= 1'b1;
                        div_q  <= DIV_START;
                        tx_q   <= '0;
                        done_q <= 1'b1;
                    end else if (rise_cnt_q != '0) begin
                        tx_q <= {tx_q[WORD_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    // Holding bytes and outputs; outputs change only on entry to VALID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl_q   <= '0;
            ph_q   <= '0;
            al_q   <= '0;
            ptch_q <= '0;
            az_q   <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= (state_d == ST_VALID);
            if (done_q) begin
                case (state_q)
                    ST_RD_PL: pl_q <= rx_q;
                    ST_RD_PH: ph_q <= rx_q;
                    ST_RD_AL: al_q <= rx_q;
                    ST_RD_AH: begin
                        ptch_q <= {ph_q, pl_q};
                        az_q   <= {rx_q, al_q};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inert_intf.sv
// Bench for inert_intf with an SPI slave model that logs commands and serves
// register reads from a small map.
module tb_inert_intf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic        MISO;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inert_intf #(.INIT_WAIT_BITS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .vld     (vld),
        .ptch_rt (ptch_rt),
        .AZ      (AZ)
    );

    // ---------------- SPI slave / IMU model ----------------
    logic [7:0]  regs [0:127];
    logic [15:0] sh_in;
    logic [15:0] resp;
    int          rise_n = 0;
    bit          int_hold = 1'b0;
    logic [15:0] cmd_log [$];

    always @(negedge SS_n) begin
        rise_n = 0;
        sh_in  = '0;
        resp   = 16'hA500;
        MISO   = resp[15];
    end

    always @(posedge SCLK) begin
        if (SS_n === 1'b0) begin
            sh_in  = {sh_in[14:0], MOSI};
            rise_n = rise_n + 1;
            if (rise_n == 8) resp[7:0] = sh_in[7] ? regs[sh_in[6:0]] : 8'h00;
        end
    end

    always @(negedge SCLK) begin
        if (SS_n === 1'b0 && rise_n > 0 && rise_n < 16) MISO = resp[15 - rise_n];
    end

    // Complete frames only; reading the AZ high byte clears data-ready.
    always @(posedge SS_n) begin
        if (rise_n == 16) begin
            cmd_log.push_back(sh_in);
            if (sh_in == 16'hAD00 && !int_hold) INT = 1'b0;
        end
        rise_n = 0;
    end

    task automatic set_regs(input logic [7:0] pl, input logic [7:0] ph,
                            input logic [7:0] al, input logic [7:0] ah);
        regs[7'h22] = pl;
        regs[7'h23] = ph;
        regs[7'h2C] = al;
        regs[7'h2D] = ah;
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok, output int vld_seen);
        int c = 0;
        vld_seen = 0;
        while (cmd_log.size() < n && c < budget) begin
            @(negedge clk);
            c++;
            if (vld) vld_seen++;
        end
        ok = (cmd_log.size() >= n);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [15:0] exp_w [0:3];
        int  c;
        bit  ok;
        int  vs;
        exp_w[0] = 16'h0D02; exp_w[1] = 16'h1053; exp_w[2] = 16'h1150; exp_w[3] = 16'h1460;
        rst_n = 1'b0;
        INT   = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (SS_n !== 1'b1) begin bad++; $display("FAIL rst_ss_n: got %b want 1", SS_n); end
        total++; if (SCLK !== 1'b1) begin bad++; $display("FAIL rst_sclk: got %b want 1", SCLK); end
        total++; if (MOSI !== 1'b0) begin bad++; $display("FAIL rst_mosi: got %b want 0", MOSI); end
        total++; if (vld !== 1'b0) begin bad++; $display("FAIL rst_vld: got %b want 0", vld); end
        total++; if (ptch_rt !== 16'h0000) begin bad++; $display("FAIL rst_ptch: got %h want 0000", ptch_rt); end
        total++; if (AZ !== 16'h0000) begin bad++; $display("FAIL rst_az: got %h want 0000", AZ); end
        rst_n = 1'b1;
        c = 0;
        while (SS_n !== 1'b0 && c < 100) begin @(negedge clk); c++; end
        total++;
        if (c < 16 || c > 18) begin bad++; $display("FAIL init_settle: got %0d clk want 16..18", c); end
        wait_log(4, 2000, ok, vs);
        total++; if (!ok) begin bad++; $display("FAIL init_writes_timeout: got %0d words want 4", cmd_log.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= cmd_log.size() || cmd_log[i] !== exp_w[i]) begin
                bad++;
                $display("FAIL init_word%0d: got %h want %h", i,
                         (i < cmd_log.size()) ? cmd_log[i] : 16'hxxxx, exp_w[i]);
            end
        end
        total++; if (vs != 0) begin bad++; $display("FAIL init_vld: got %0d pulses want 0", vs); end
        cmd_log.delete();
    endtask

    task automatic test_read_set();
        logic [15:0] exp_c [0:3];
        int  c;
        bit  found;
        int  ss_act;
        int  vcnt;
        exp_c[0] = 16'hA200; exp_c[1] = 16'hA300; exp_c[2] = 16'hAC00; exp_c[3] = 16'hAD00;
        set_regs(8'h34, 8'h12, 8'h78, 8'h56);
        repeat (20) @(negedge clk);
        INT = 1'b1;
        c = 0; found = 1'b0;
        while (!found && c < 1500) begin @(negedge clk); c++; if (vld) found = 1'b1; end
        total++; if (!found) begin bad++; $display("FAIL rd_vld_timeout: got none within %0d clk want pulse", c); end
        total++; if (c > 4 * 263 + 6) begin bad++; $display("FAIL rd_latency: got %0d clk want <= %0d", c, 4 * 263 + 6); end
        total++; if (ptch_rt !== 16'h1234) begin bad++; $display("FAIL rd_ptch: got %h want 1234", ptch_rt); end
        total++; if (AZ !== 16'h5678) begin bad++; $display("FAIL rd_az: got %h want 5678", AZ); end
        @(negedge clk);
        total++; if (vld !== 1'b0) begin bad++; $display("FAIL rd_vld_width: got %b want 0", vld); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= cmd_log.size() || cmd_log[i] !== exp_c[i]) begin
                bad++;
                $display("FAIL rd_cmd%0d: got %h want %h", i,
                         (i < cmd_log.size()) ? cmd_log[i] : 16'hxxxx, exp_c[i]);
            end
        end
        total++; if (INT !== 1'b0) begin bad++; $display("FAIL rd_int_clear: got %b want 0", INT); end
        ss_act = 0; vcnt = 0;
        repeat (600) begin @(negedge clk); if (!SS_n) ss_act++; if (vld) vcnt++; end
        total++; if (ss_act != 0 || vcnt != 0) begin bad++; $display("FAIL rd_quiet: got ss=%0d vld=%0d want 0 0", ss_act, vcnt); end
        cmd_log.delete();
    endtask

    task automatic test_spi_waveform();
        int c;
        int low_cnt;
        int falls;
        int fall_pos [0:15];
        int mosi_bad;
        int sp_bad;
        bit prev_sclk;
        bit prev_mosi;
        bit found;
        set_regs(8'hCD, 8'hAB, 8'h01, 8'hEF);
        INT = 1'b1;
        c = 0;
        while (SS_n !== 1'b0 && c < 100) begin @(negedge clk); c++; end
        total++; if (SS_n !== 1'b0) begin bad++; $display("FAIL wf_start: got SS_n=%b want 0", SS_n); end
        total++; if (SCLK !== 1'b1) begin bad++; $display("FAIL wf_sclk_at_fall: got %b want 1", SCLK); end
        low_cnt = 1; falls = 0; mosi_bad = 0;
        prev_sclk = SCLK; prev_mosi = MOSI;
        while (low_cnt < 400) begin
            @(negedge clk);
            if (SS_n) break;
            if (prev_sclk && !SCLK) begin
                if (falls < 16) fall_pos[falls] = low_cnt;
                falls++;
            end
            if (!prev_sclk && SCLK && MOSI !== prev_mosi) mosi_bad++;
            prev_sclk = SCLK; prev_mosi = MOSI;
            low_cnt++;
        end
        total++; if (SCLK !== 1'b1) begin bad++; $display("FAIL wf_sclk_at_rise: got %b want 1", SCLK); end
        total++; if (low_cnt != 260) begin bad++; $display("FAIL wf_ss_low: got %0d clk want 260", low_cnt); end
        total++; if (falls != 16) begin bad++; $display("FAIL wf_falls: got %0d want 16", falls); end
        total++; if (falls > 0 && fall_pos[0] != 4) begin bad++; $display("FAIL wf_first_fall: got %0d want 4", fall_pos[0]); end
        sp_bad = 0;
        for (int i = 1; i < 16; i++) if (i < falls && fall_pos[i] - fall_pos[i-1] != 16) sp_bad++;
        total++; if (sp_bad != 0) begin bad++; $display("FAIL wf_spacing: got %0d bad gaps want 0", sp_bad); end
        total++; if (mosi_bad != 0) begin bad++; $display("FAIL wf_mosi_stable: got %0d changes want 0", mosi_bad); end
        c = 0; found = 1'b0;
        while (!found && c < 1500) begin @(negedge clk); c++; if (vld) found = 1'b1; end
        total++; if (!found || ptch_rt !== 16'hABCD || AZ !== 16'hEF01) begin
            bad++; $display("FAIL wf_result: got vld=%b %h/%h want 1 abcd/ef01", found, ptch_rt, AZ);
        end
        cmd_log.delete();
    endtask

    task automatic test_no_interrupt();
        int ss_act = 0;
        int vcnt   = 0;
        INT = 1'b0;
        repeat (10000) begin @(negedge clk); if (!SS_n) ss_act++; if (vld) vcnt++; end
        total++; if (ss_act != 0) begin bad++; $display("FAIL noint_ss: got %0d low clk want 0", ss_act); end
        total++; if (vcnt != 0) begin bad++; $display("FAIL noint_vld: got %0d pulses want 0", vcnt); end
        total++; if (ptch_rt !== 16'hABCD || AZ !== 16'hEF01) begin
            bad++; $display("FAIL noint_hold: got %h/%h want abcd/ef01", ptch_rt, AZ);
        end
    endtask

    task automatic test_continuous();
        int c;
        bit found;
        int ss_act;
        int vcnt;
        set_regs(8'hFF, 8'h7F, 8'h00, 8'h80);
        int_hold = 1'b1;
        INT = 1'b1;
        c = 0; found = 1'b0;
        while (!found && c < 1500) begin @(negedge clk); c++; if (vld) found = 1'b1; end
        total++; if (!found || ptch_rt !== 16'h7FFF || AZ !== 16'h8000) begin
            bad++; $display("FAIL cont_set1: got vld=%b %h/%h want 1 7fff/8000", found, ptch_rt, AZ);
        end
        set_regs(8'h01, 8'h00, 8'h02, 8'h00);
        @(negedge clk);
        total++; if (vld !== 1'b0) begin bad++; $display("FAIL cont_vld_width: got %b want 0", vld); end
        c = 0; found = 1'b0;
        while (!found && c < 1200) begin @(negedge clk); c++; if (vld) found = 1'b1; end
        total++; if (!found || ptch_rt !== 16'h0001 || AZ !== 16'h0002) begin
            bad++; $display("FAIL cont_set2: got vld=%b %h/%h want 1 0001/0002", found, ptch_rt, AZ);
        end
        c = 0;
        while (SS_n !== 1'b0 && c < 50) begin @(negedge clk); c++; end
        total++; if (SS_n !== 1'b0) begin bad++; $display("FAIL cont_restart: got SS_n=%b within %0d clk want 0", SS_n, c); end
        // Data-ready drops mid-set: the set still completes.
        int_hold = 1'b0;
        INT = 1'b0;
        c = 0; found = 1'b0;
        while (!found && c < 1500) begin @(negedge clk); c++; if (vld) found = 1'b1; end
        total++; if (!found || ptch_rt !== 16'h0001 || AZ !== 16'h0002) begin
            bad++; $display("FAIL cont_set3: got vld=%b %h/%h want 1 0001/0002", found, ptch_rt, AZ);
        end
        ss_act = 0; vcnt = 0;
        repeat (1500) begin @(negedge clk); if (!SS_n) ss_act++; if (vld) vcnt++; end
        total++; if (ss_act != 0 || vcnt != 0) begin bad++; $display("FAIL cont_stop: got ss=%0d vld=%0d want 0 0", ss_act, vcnt); end
        cmd_log.delete();
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_w [0:4];
        int  c;
        int  nfall;
        bit  prev_ss;
        bit  ok;
        int  vs;
        bit  found;
        exp_w[0] = 16'h0D02; exp_w[1] = 16'h1053; exp_w[2] = 16'h1150;
        exp_w[3] = 16'h1460; exp_w[4] = 16'hA200;
        set_regs(8'h11, 8'h22, 8'h33, 8'h44);
        INT = 1'b1;
        c = 0; nfall = 0; prev_ss = 1'b1;
        while (nfall < 3 && c < 1500) begin
            @(negedge clk); c++;
            if (prev_ss && !SS_n) nfall++;
            prev_ss = SS_n;
        end
        total++; if (nfall != 3) begin bad++; $display("FAIL mid_reach_al: got %0d frames want 3", nfall); end
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (SS_n !== 1'b1 || SCLK !== 1'b1) begin
            bad++; $display("FAIL mid_rst_lines: got SS_n=%b SCLK=%b want 1 1", SS_n, SCLK);
        end
        total++; if (vld !== 1'b0 || ptch_rt !== 16'h0000 || AZ !== 16'h0000) begin
            bad++; $display("FAIL mid_rst_outs: got vld=%b %h/%h want 0 0000/0000", vld, ptch_rt, AZ);
        end
        total++; if (cmd_log.size() != 2) begin bad++; $display("FAIL mid_partial_log: got %0d words want 2", cmd_log.size()); end
        cmd_log.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        while (SS_n !== 1'b0 && c < 100) begin @(negedge clk); c++; end
        total++; if (c < 16 || c > 18) begin bad++; $display("FAIL mid_settle: got %0d clk want 16..18", c); end
        wait_log(5, 2500, ok, vs);
        total++; if (!ok) begin bad++; $display("FAIL mid_log_timeout: got %0d words want 5", cmd_log.size()); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= cmd_log.size() || cmd_log[i] !== exp_w[i]) begin
                bad++;
                $display("FAIL mid_word%0d: got %h want %h", i,
                         (i < cmd_log.size()) ? cmd_log[i] : 16'hxxxx, exp_w[i]);
            end
        end
        total++; if (vs != 0) begin bad++; $display("FAIL mid_early_vld: got %0d pulses want 0", vs); end
        c = 0; found = 1'b0;
        while (!found && c < 1500) begin @(negedge clk); c++; if (vld) found = 1'b1; end
        total++; if (!found || ptch_rt !== 16'h2211 || AZ !== 16'h4433) begin
            bad++; $display("FAIL mid_result: got vld=%b %h/%h want 1 2211/4433", found, ptch_rt, AZ);
        end
    endtask

    initial begin
        MISO = 1'b0;
        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
        test_reset();
        test_read_set();
        test_spi_waveform();
        test_no_interrupt();
        test_continuous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
